// File: rtl/rib_arbiter_param.sv
// N-master / M-slave RIB interconnect: registered fixed-priority or round-robin arbitration,
// per-transaction req/ready handshake, slave timeout and address-decode error.
module rib_arbiter_param #(
  parameter int N_MASTERS   = 4,
  parameter int N_SLAVES    = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int CORE_MASTER = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_data_o,
  output logic [N_SLAVES-1:0]           s_we_o,
  output logic [N_SLAVES-1:0]           s_req_o,
  input  logic [N_SLAVES*DATA_W-1:0]    s_data_i,
  input  logic [N_SLAVES-1:0]           s_ready_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic                          hold_flag_o
);

  localparam int MW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t              r_state;
  logic [MW-1:0]       r_ptr;
  logic [MW-1:0]       r_owner;
  logic [CW-1:0]       r_cnt;
  logic                r_we;

  logic [MW-1:0]       w_base;
  logic [2*N_MASTERS-1:0] w_req_rot;
  logic                w_any;
  logic [MW-1:0]       w_win;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wwe;
  logic [3:0]          w_wsel;
  logic                w_wsel_ok;
  logic [3:0]          w_sel;
  logic                w_sel_ok;
  logic [DATA_W-1:0]   w_sdat;
  logic                w_srdy;

  // Rotating the request vector by the pointer turns round-robin into a lowest-index search.
  assign w_base    = (ARB_MODE == 1) ? r_ptr : '0;
  assign w_req_rot = {m_req_i, m_req_i} >> w_base;

  always_comb begin
    int v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_idx = 0;
    for (int j = 0; j < N_MASTERS; j++) begin
      if (!w_any && w_req_rot[j]) begin
        w_any = 1'b1;
        v_idx = int'(w_base) + j;
        if (v_idx >= N_MASTERS) v_idx = v_idx - N_MASTERS;
        w_win = MW'(v_idx);
      end
    end
  end

  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    w_wwe   = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_win == MW'(i)) begin
        w_waddr = m_addr_i[i*ADDR_W +: ADDR_W];
        w_wdata = m_data_i[i*DATA_W +: DATA_W];
        w_wwe   = m_we_i[i];
      end
    end
  end

  assign w_wsel    = w_waddr[ADDR_W-1 -: 4];
  assign w_wsel_ok = ({1'b0, w_wsel} < 5'(N_SLAVES));
  assign w_sel     = s_addr_o[ADDR_W-1 -: 4];
  assign w_sel_ok  = ({1'b0, w_sel} < 5'(N_SLAVES));

  always_comb begin
    w_sdat = '0;
    w_srdy = 1'b0;
    for (int s = 0; s < N_SLAVES; s++) begin
      if (w_sel == 4'(s)) begin
        w_sdat = s_data_i[s*DATA_W +: DATA_W];
        w_srdy = s_ready_i[s];
      end
    end
  end

  assign hold_flag_o = m_req_i[CORE_MASTER] &
                       ((r_state == ST_IDLE) | (r_owner != MW'(CORE_MASTER)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      m_data_o  <= '0;
      m_ready_o <= '0;
      m_err_o   <= '0;
      s_addr_o  <= '0;
      s_data_o  <= '0;
      s_we_o    <= '0;
      s_req_o   <= '0;
      grant_o   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner  <= w_win;
            grant_o  <= N_MASTERS'(1) << w_win;
            s_addr_o <= w_waddr;
            s_data_o <= w_wdata;
            r_we     <= w_wwe;
            r_cnt    <= '0;
            // Strobes are registered here so they line up with the ACCESS cycle.
            if (w_wsel_ok) begin
              s_req_o <= N_SLAVES'(1) << w_wsel;
              s_we_o  <= w_wwe ? (N_SLAVES'(1) << w_wsel) : '0;
            end
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!w_sel_ok || (!w_srdy && r_cnt == CW'(TIMEOUT - 1))) begin
            m_data_o  <= '0;
            m_ready_o <= grant_o;
            m_err_o   <= grant_o;
            s_req_o   <= '0;
            s_we_o    <= '0;
            r_state   <= ST_RESP;
          end else if (w_srdy) begin
            m_data_o  <= r_we ? '0 : w_sdat;
            m_ready_o <= grant_o;
            s_req_o   <= '0;
            s_we_o    <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          m_ready_o <= '0;
          m_err_o   <= '0;
          grant_o   <= '0;
          r_cnt     <= '0;
          if (ARB_MODE == 1) begin
            r_ptr <= (r_owner == MW'(N_MASTERS - 1)) ? '0 : r_owner + 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arbiter_param.sv
// Bench for rib_arbiter_param: a fixed-priority and a round-robin instance share the slave side;
// expected completions are queued at issue time and checked by a separate monitor.
module tb_rib_arbiter_param;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [3:0]   req0, we0, req1, we1;
  logic [31:0]  a0 [4];
  logic [31:0]  d0 [4];
  logic [31:0]  a1 [4];
  logic [127:0] addr0, wdat0, addr1, wdat1;
  logic [31:0]  sd [8];
  logic [255:0] s_data;
  logic [7:0]   s_rdy;

  logic [31:0]  rdat0, rdat1, saddr0, saddr1, sdat0, sdat1;
  logic [3:0]   rdy0, rdy1, err0, err1, grant0, grant1;
  logic [7:0]   swe0, swe1, sreq0, sreq1;
  logic         hold0, hold1;

  always_comb begin
    addr0 = '0; wdat0 = '0; addr1 = '0; wdat1 = '0; s_data = '0;
    for (int i = 0; i < 4; i++) begin
      addr0[i*32 +: 32] = a0[i];
      wdat0[i*32 +: 32] = d0[i];
      addr1[i*32 +: 32] = a1[i];
    end
    for (int k = 0; k < 8; k++) s_data[k*32 +: 32] = sd[k];
  end

  rib_arbiter_param #(.ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst_n),
    .m_req_i(req0), .m_we_i(we0), .m_addr_i(addr0), .m_data_i(wdat0),
    .m_data_o(rdat0), .m_ready_o(rdy0), .m_err_o(err0),
    .s_addr_o(saddr0), .s_data_o(sdat0), .s_we_o(swe0), .s_req_o(sreq0),
    .s_data_i(s_data), .s_ready_i(s_rdy),
    .grant_o(grant0), .hold_flag_o(hold0)
  );

  rib_arbiter_param #(.ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst_n),
    .m_req_i(req1), .m_we_i(we1), .m_addr_i(addr1), .m_data_i(wdat1),
    .m_data_o(rdat1), .m_ready_o(rdy1), .m_err_o(err1),
    .s_addr_o(saddr1), .s_data_o(sdat1), .s_we_o(swe1), .s_req_o(sreq1),
    .s_data_i(s_data), .s_ready_i(s_rdy),
    .grant_o(grant1), .hold_flag_o(hold1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [3:0] rdy,
                     input logic [3:0] err, input logic [31:0] dat);
    logic [3:0] oh;
    oh = 4'b0001 << e.m;
    n_vec++;
    if (rdy !== oh || err !== (e.e ? oh : 4'b0000) || dat !== e.d || cyc != e.c) begin
      n_bad++;
      $display("FAIL %s: got ready=%b err=%b data=%h cyc=%0d expected ready=%b err=%b data=%h cyc=%0d",
               nm, rdy, err, dat, cyc, oh, e.e ? oh : 4'b0000, e.d, e.c);
    end
  endtask

  // Completion monitor: ready is high for exactly the RESP cycle, observed on the falling edge.
  always @(negedge clk) begin
    if (rdy0 != 0 || err0 != 0) begin
      if (q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL fp_unexpected: got ready=%b err=%b expected no completion (cycle %0d)", rdy0, err0, cyc);
      end else cmp("fp_completion", q0.pop_front(), rdy0, err0, rdat0);
    end
    if (rdy1 != 0 || err1 != 0) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rr_unexpected: got ready=%b err=%b expected no completion (cycle %0d)", rdy1, err1, cyc);
      end else cmp("rr_completion", q1.pop_front(), rdy1, err1, rdat1);
    end
  end

  // Fixed-priority masters release their request when they see their ready pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (rdy0[i]) req0[i] = 1'b0;
  end

  int   sreq2_cnt = 0;
  logic [7:0] sreq_or = '0;
  always @(negedge clk) begin
    if (sreq0[2]) sreq2_cnt++;
    sreq_or = sreq_or | sreq0 | swe0;
  end

  task automatic push0(input int m, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.m = m; x.d = d; x.e = e; x.c = c;
    q0.push_back(x);
  endtask

  task automatic push1(input int m, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.m = m; x.d = d; x.e = e; x.c = c;
    q1.push_back(x);
  endtask

  task automatic issue0(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    a0[m] = a; d0[m] = d; we0[m] = we; req0[m] = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int budget);
    int b;
    b = budget;
    while ((q0.size() != 0 || q1.size() != 0) && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: got %0d pending completions expected 0", nm, q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst_n = 1'b0;
    req0 = '0; we0 = '0; req1 = '0; we1 = '0;
    for (int i = 0; i < 4; i++) begin a0[i] = '0; d0[i] = '0; a1[i] = '0; end
    for (int k = 0; k < 8; k++) sd[k] = 32'h5100_0000 + k;
    sd[1] = 32'hDEAD_BEEF;
    s_rdy = 8'hFF;
    wdat1 = '0;

    repeat (2) @(negedge clk);
    chk("reset_ctrl", {35'd0, rdy0, err0, grant0, swe0, sreq0, hold0}, 64'd0);
    chk("reset_data", {rdat0, saddr0}, 64'd0);
    chk("reset_rr",   {35'd0, rdy1, err1, grant1, swe1, sreq1, hold1}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read from zero-wait slave 1.
    c0 = cyc;
    issue0(1, 1'b0, 32'h1000_0004, 32'h0);
    push0(1, 32'hDEAD_BEEF, 1'b0, c0 + 2);
    wait_cyc(c0 + 1);
    chk("single_grant", {60'd0, grant0}, 64'h2);
    chk("single_sreq",  {56'd0, sreq0}, 64'h02);
    chk("single_saddr", {32'd0, saddr0}, 64'h1000_0004);
    drain("single", 10);

    // Masters 0 (read slave 3) and 2 (write slave 4) collide; lowest index first.
    c0 = cyc;
    issue0(0, 1'b0, 32'h3000_0000, 32'h0);
    issue0(2, 1'b1, 32'h4000_0010, 32'hCAFE_0002);
    push0(0, 32'h5100_0003, 1'b0, c0 + 2);
    push0(2, 32'h0000_0000, 1'b0, c0 + 5);
    wait_cyc(c0 + 4);
    chk("fp_second_grant", {60'd0, grant0}, 64'h4);
    chk("fp_write_we",     {56'd0, swe0}, 64'h10);
    chk("fp_write_data",   {32'd0, sdat0}, 64'hCAFE_0002);
    drain("fixed_prio", 20);
    we0[2] = 1'b0;

    // Slave 2 stalls five cycles, answers in the sixth.
    s_rdy[2] = 1'b0;
    sreq2_cnt = 0;
    c0 = cyc;
    issue0(3, 1'b0, 32'h2000_0008, 32'h0);
    push0(3, 32'h5100_0002, 1'b0, c0 + 7);
    wait_cyc(c0 + 6);
    s_rdy[2] = 1'b1;
    drain("wait_state", 20);
    chk("wait_sreq_cycles", 64'(sreq2_cnt), 64'd6);

    // Slave 5 never answers.
    s_rdy[5] = 1'b0;
    c0 = cyc;
    issue0(0, 1'b0, 32'h5000_0000, 32'h0);
    push0(0, 32'h0000_0000, 1'b1, c0 + 17);
    drain("timeout", 40);
    s_rdy[5] = 1'b1;

    // Address decodes beyond the last slave.
    sreq_or = '0;
    c0 = cyc;
    issue0(1, 1'b0, 32'hA000_0000, 32'h0);
    push0(1, 32'h0000_0000, 1'b1, c0 + 2);
    drain("decode_err", 10);
    chk("decode_no_strobe", {56'd0, sreq_or}, 64'h0);

    // Reset while in ACCESS: abort silently.
    c0 = cyc;
    issue0(2, 1'b0, 32'h1000_0000, 32'h0);
    wait_cyc(c0 + 1);
    chk("abort_pre_grant", {60'd0, grant0}, 64'h4);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {35'd0, rdy0, err0, grant0, swe0, sreq0, hold0}, 64'd0);
    chk("abort_addr", {32'd0, saddr0}, 64'd0);
    req0 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_idle", {60'd0, grant0}, 64'h0);

    // Round-robin: all four masters request continuously.
    for (int i = 0; i < 4; i++) a1[i] = 32'(i + 1) << 28;
    c0 = cyc;
    req1 = 4'hF;
    push1(0, 32'hDEAD_BEEF, 1'b0, c0 + 2);
    push1(1, 32'h5100_0002, 1'b0, c0 + 5);
    push1(2, 32'h5100_0003, 1'b0, c0 + 8);
    push1(3, 32'h5100_0004, 1'b0, c0 + 11);
    push1(0, 32'hDEAD_BEEF, 1'b0, c0 + 14);
    wait_cyc(c0 + 1);
    chk("rr_core_owner_hold", {63'd0, hold1}, 64'd0);
    wait_cyc(c0 + 4);
    chk("rr_other_owner_hold", {63'd0, hold1}, 64'd1);
    chk("rr_second_grant", {60'd0, grant1}, 64'h2);
    wait_cyc(c0 + 14);
    req1 = 4'h0;
    drain("round_robin", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
